// File: rtl/stepper_position_ctrl_if.sv
// Command port of the stepper position controller:
// absolute target, channel and step mode over valid/ready.
interface stepper_position_ctrl_if #(
  parameter int NUM_CH = 2,
  parameter int POS_W  = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [CH_W-1:0]  cmd_ch;
  logic [POS_W-1:0] cmd_target;
  logic             cmd_half;

  modport master (
    output cmd_valid,
    output cmd_ch,
    output cmd_target,
    output cmd_half,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_ch,
    input  cmd_target,
    input  cmd_half,
    output cmd_ready
  );
endinterface

// File: rtl/stepper_position_ctrl.sv
// Multi-channel stepper position controller: shared step tick,
// full/half stepping toward a target, then a timed holding torque.
module stepper_position_ctrl #(
  parameter int NUM_CH     = 2,
  parameter int POS_W      = 8,
  parameter int STEP_DIV   = 25000,
  parameter int HOLD_TICKS = 50
) (
  input  logic                    clk,
  input  logic                    reset,
  stepper_position_ctrl_if.slave  cmd,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH*POS_W-1:0] pos,
  output logic [NUM_CH*4-1:0]     coil,
  output logic [NUM_CH*2-1:0]     pwm,
  output logic [NUM_CH-1:0]       done
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TC_W = $clog2(STEP_DIV);
  localparam int HC_W = $clog2(HOLD_TICKS + 1);

  localparam logic [TC_W-1:0] TC_MAX = TC_W'(STEP_DIV - 1);
  localparam logic [HC_W-1:0] HC_LD  = HC_W'(HOLD_TICKS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVE,
    S_HOLD
  } st_e;

  function automatic logic [3:0] ph2coil(input logic [2:0] p);
    logic [3:0] c;
    unique case (p)
      3'd0: c = 4'b1000;
      3'd1: c = 4'b1010;
      3'd2: c = 4'b0010;
      3'd3: c = 4'b0110;
      3'd4: c = 4'b0100;
      3'd5: c = 4'b0101;
      3'd6: c = 4'b0001;
      3'd7: c = 4'b1001;
    endcase
    return c;
  endfunction

  logic [TC_W-1:0]   tcnt_q, tcnt_d;
  logic              tick;
  logic [NUM_CH-1:0] free;

  assign tick = (tcnt_q == TC_MAX);

  // step-rate divider, shared by every channel
  always_comb begin
    tcnt_d = tick ? '0 : tcnt_q + TC_W'(1);
  end

  // divider register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tcnt_q <= '0;
    else        tcnt_q <= tcnt_d;
  end

  // ready follows the addressed channel; unknown channels swallow it
  always_comb begin
    cmd.cmd_ready = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cmd.cmd_ch == CH_W'(c)) cmd.cmd_ready = free[c];
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    st_e              st_q, st_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [POS_W-1:0] tgt_q, tgt_d;
    logic [POS_W-1:0] pos_nx;
    logic             half_q, half_d;
    logic [2:0]       ph_q, ph_d, stp;
    logic [HC_W-1:0]  hc_q, hc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [3:0]       coil_q, coil_d;
    logic [1:0]       pwm_q, pwm_d;
    logic             acc, up;

    assign free[c] = (st_q != S_MOVE);
    assign acc     = cmd.cmd_valid && free[c]
                  && (cmd.cmd_ch == CH_W'(c));
    assign up      = (tgt_q > pos_q);
    assign stp     = half_q ? 3'd1 : 3'd2;
    assign pos_nx  = up ? pos_q + POS_W'(1)
                        : pos_q - POS_W'(1);

    // next state; an accept masks a coincident tick
    always_comb begin
      st_d   = st_q;
      pos_d  = pos_q;
      tgt_d  = tgt_q;
      half_d = half_q;
      ph_d   = ph_q;
      hc_d   = hc_q;
      done_d = 1'b0;
      if (acc) begin
        tgt_d  = cmd.cmd_target;
        half_d = cmd.cmd_half;
        if (cmd.cmd_target == pos_q) begin
          st_d   = S_HOLD;
          hc_d   = HC_LD;
          done_d = 1'b1;
        end else begin
          st_d = S_MOVE;
        end
      end else if (tick) begin
        unique case (st_q)
          S_MOVE: begin
            pos_d = pos_nx;
            ph_d  = up ? ph_q + stp : ph_q - stp;
            if (pos_nx == tgt_q) begin
              st_d   = S_HOLD;
              hc_d   = HC_LD;
              done_d = 1'b1;
            end
          end
          S_HOLD: begin
            hc_d = hc_q - HC_W'(1);
            if (hc_q == HC_W'(1)) st_d = S_IDLE;
          end
          default: ;
        endcase
      end
      busy_d = (st_d == S_MOVE);
      coil_d = (st_d == S_IDLE) ? 4'b0000 : ph2coil(ph_d);
      pwm_d  = (st_d == S_IDLE) ? 2'b00 : 2'b11;
    end

    // channel state and registered outputs
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        st_q   <= S_IDLE;
        pos_q  <= '0;
        tgt_q  <= '0;
        half_q <= 1'b0;
        ph_q   <= '0;
        hc_q   <= '0;
        busy_q <= 1'b0;
        done_q <= 1'b0;
        coil_q <= '0;
        pwm_q  <= '0;
      end else begin
        st_q   <= st_d;
        pos_q  <= pos_d;
        tgt_q  <= tgt_d;
        half_q <= half_d;
        ph_q   <= ph_d;
        hc_q   <= hc_d;
        busy_q <= busy_d;
        done_q <= done_d;
        coil_q <= coil_d;
        pwm_q  <= pwm_d;
      end
    end

    assign busy[c]               = busy_q;
    assign done[c]               = done_q;
    assign pos[c*POS_W +: POS_W] = pos_q;
    assign coil[c*4 +: 4]        = coil_q;
    assign pwm[c*2 +: 2]         = pwm_q;
  end

endmodule

// File: tb/tb_stepper_position_ctrl.sv
// Bench for stepper_position_ctrl: step scoreboard, command
// table and timed sequences for tick, hold and reset corners.
module tb_stepper_position_ctrl;
  localparam int NCH = 2;
  localparam int PW  = 8;
  localparam int SD  = 4;
  localparam int HT  = 2;

  localparam logic [3:0] COIL_T [8] = '{
    4'b1000, 4'b1010, 4'b0010, 4'b0110,
    4'b0100, 4'b0101, 4'b0001, 4'b1001
  };

  typedef struct {
    int         pos;
    logic [3:0] coil;
  } step_t;

  typedef struct {
    int         ch;
    int         tgt;
    bit         half;
    int         exp_pos;
    logic [3:0] exp_coil;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stepper_position_ctrl_if #(.NUM_CH(NCH), .POS_W(PW)) ifc ();
  logic [NCH-1:0]    busy, done;
  logic [NCH*PW-1:0] pos;
  logic [NCH*4-1:0]  coil;
  logic [NCH*2-1:0]  pwm;

  stepper_position_ctrl #(
    .NUM_CH(NCH), .POS_W(PW), .STEP_DIV(SD), .HOLD_TICKS(HT)
  ) dut (
    .clk(clk), .reset(rst_n), .cmd(ifc),
    .busy(busy), .pos(pos), .coil(coil),
    .pwm(pwm), .done(done)
  );

  stepper_position_ctrl_if #(.NUM_CH(3), .POS_W(PW)) ifc3 ();
  logic [2:0]    busy3, done3;
  logic [3*PW-1:0] pos3;
  logic [11:0]   coil3;
  logic [5:0]    pwm3;

  stepper_position_ctrl #(
    .NUM_CH(3), .POS_W(PW), .STEP_DIV(SD), .HOLD_TICKS(HT)
  ) dut3 (
    .clk(clk), .reset(rst_n), .cmd(ifc3),
    .busy(busy3), .pos(pos3), .coil(coil3),
    .pwm(pwm3), .done(done3)
  );

  int    checks = 0;
  int    errors = 0;
  int    ecnt;
  step_t sq [NCH][$];
  int    dq [NCH][$];
  int    mpos [NCH];
  int    mph [NCH];
  int    prev [NCH];
  vec_t  tbl [6];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model_push(input int ch, input int tgt,
                            input bit half);
    step_t e;
    int d;
    d = half ? 1 : 2;
    while (mpos[ch] != tgt) begin
      if (tgt > mpos[ch]) begin
        mpos[ch]++;
        mph[ch] = (mph[ch] + d) % 8;
      end else begin
        mpos[ch]--;
        mph[ch] = (mph[ch] + 8 - d) % 8;
      end
      e.pos  = mpos[ch];
      e.coil = COIL_T[mph[ch]];
      sq[ch].push_back(e);
    end
    dq[ch].push_back(tgt);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mpos[c] = 0;
      mph[c]  = 0;
      prev[c] = 0;
      sq[c].delete();
      dq[c].delete();
    end
  endtask

  // called at a falling edge; returns at the falling edge after accept
  task automatic send(input int ch, input int tgt, input bit half);
    int n;
    n = 0;
    ifc.cmd_valid  = 1'b1;
    ifc.cmd_ch     = 1'(ch);
    ifc.cmd_target = 8'(tgt);
    ifc.cmd_half   = half;
    #1;
    while (!ifc.cmd_ready && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!ifc.cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL send timeout: ch %0d ready never rose", ch);
    end else begin
      model_push(ch, tgt, half);
    end
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
  endtask

  task automatic wait_ecnt(input int n);
    int k;
    k = 0;
    while (ecnt < n && k < 1000) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic align(input int r);
    int k;
    k = 0;
    while ((ecnt % SD) != r && k < 2 * SD) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy != '0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("idle wait", 32'(busy), 32'd0);
  endtask

  // scoreboard: every position change and done pulse is popped
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int c = 0; c < NCH; c++) begin
          int p;
          step_t e;
          p = int'(pos[c*PW +: PW]);
          if (p != prev[c]) begin
            if (sq[c].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL step ch%0d: unexpected pos %0d", c, p);
            end else begin
              e = sq[c].pop_front();
              chk($sformatf("step ch%0d pos", c), 32'(p), 32'(e.pos));
              chk($sformatf("step ch%0d coil", c),
                  32'(coil[c*4 +: 4]), 32'(e.coil));
            end
            prev[c] = p;
          end
          if (done[c]) begin
            if (dq[c].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL done ch%0d: unexpected pulse", c);
            end else begin
              chk($sformatf("done ch%0d pos", c), 32'(p),
                  32'(dq[c].pop_front()));
              chk($sformatf("done ch%0d busy", c),
                  32'(busy[c]), 32'd0);
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e0;
    int k;
    bit seen;

    tbl[0] = '{1, 2, 1'b0, 2, 4'b0100};
    tbl[1] = '{1, 0, 1'b0, 0, 4'b1000};
    tbl[2] = '{0, 3, 1'b1, 3, 4'b0110};
    tbl[3] = '{0, 1, 1'b0, 1, 4'b1001};
    tbl[4] = '{0, 4, 1'b1, 4, 4'b0010};
    tbl[5] = '{1, 5, 1'b0, 5, 4'b0010};

    ifc.cmd_valid   = 1'b0;
    ifc.cmd_ch      = '0;
    ifc.cmd_target  = '0;
    ifc.cmd_half    = 1'b0;
    ifc3.cmd_valid  = 1'b0;
    ifc3.cmd_ch     = '0;
    ifc3.cmd_target = '0;
    ifc3.cmd_half   = 1'b0;
    model_reset();

    repeat (2) @(negedge clk);
    chk("rst pos", pos, 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst coil", 32'(coil), 32'd0);
    chk("rst pwm", 32'(pwm), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst ready", 32'(ifc.cmd_ready), 32'd1);
    #2 rst_n = 1'b1;

    // half-step forward with exact tick timing
    wait_ecnt(4);
    send(0, 3, 1'b1);
    chk("hs busy", 32'(busy[0]), 32'd1);
    chk("hs pos0", 32'(pos[7:0]), 32'd0);
    chk("hs coil0", 32'(coil[3:0]), 32'b1000);
    chk("hs pwm0", 32'(pwm[1:0]), 32'b11);
    wait_ecnt(8);
    chk("hs s1 pos", 32'(pos[7:0]), 32'd1);
    chk("hs s1 coil", 32'(coil[3:0]), 32'b1010);
    wait_ecnt(12);
    chk("hs s2 coil", 32'(coil[3:0]), 32'b0010);
    wait_ecnt(16);
    chk("hs s3 pos", 32'(pos[7:0]), 32'd3);
    chk("hs s3 coil", 32'(coil[3:0]), 32'b0110);
    chk("hs done", 32'(done[0]), 32'd1);
    chk("hs busy off", 32'(busy[0]), 32'd0);
    wait_ecnt(17);
    chk("hs done 1cyc", 32'(done[0]), 32'd0);
    wait_ecnt(23);
    chk("hs hold pwm", 32'(pwm[1:0]), 32'b11);
    wait_ecnt(24);
    chk("hs idle pwm", 32'(pwm[1:0]), 32'b00);
    chk("hs idle coil", 32'(coil[3:0]), 32'b0000);

    // command table
    for (int i = 0; i < 6; i++) begin
      k = 0;
      send(tbl[i].ch, tbl[i].tgt, tbl[i].half);
      while (!done[tbl[i].ch] && k < 200) begin
        @(negedge clk);
        k++;
      end
      chk($sformatf("row%0d done", i),
          32'(done[tbl[i].ch]), 32'd1);
      chk($sformatf("row%0d pos", i),
          32'(pos[tbl[i].ch*PW +: PW]), 32'(tbl[i].exp_pos));
      chk($sformatf("row%0d coil", i),
          32'(coil[tbl[i].ch*4 +: 4]), 32'(tbl[i].exp_coil));
      chk($sformatf("row%0d pwm", i),
          32'(pwm[tbl[i].ch*2 +: 2]), 32'b11);
    end

    // zero-length move: done next cycle, two ticks of hold
    align(0);
    send(0, 4, 1'b0);
    e0 = ecnt;
    chk("zl done", 32'(done[0]), 32'd1);
    chk("zl busy", 32'(busy[0]), 32'd0);
    wait_ecnt(e0 + 6);
    chk("zl hold pwm", 32'(pwm[1:0]), 32'b11);
    wait_ecnt(e0 + 7);
    chk("zl idle pwm", 32'(pwm[1:0]), 32'b00);

    // handshake: busy channel stalls, other channel flows
    send(0, 12, 1'b1);
    ifc.cmd_valid  = 1'b1;
    ifc.cmd_ch     = 1'b0;
    ifc.cmd_target = 8'd20;
    #1;
    chk("hk ready ch0", 32'(ifc.cmd_ready), 32'd0);
    ifc.cmd_ch = 1'b1;
    #1;
    chk("hk ready ch1", 32'(ifc.cmd_ready), 32'd1);
    ifc.cmd_valid = 1'b0;
    send(1, 7, 1'b1);
    chk("hk ch1 busy", 32'(busy[1]), 32'd1);
    send(0, 6, 1'b0);
    chk("hk held", 32'(pos[7:0]), 32'd12);

    // accept on a tick edge: first step a full period later
    wait_idle();
    align(SD - 1);
    send(1, 8, 1'b1);
    e0 = ecnt;
    chk("tk busy", 32'(busy[1]), 32'd1);
    wait_ecnt(e0 + SD - 1);
    chk("tk no step", 32'(pos[15:8]), 32'd7);
    wait_ecnt(e0 + SD);
    chk("tk step", 32'(pos[15:8]), 32'd8);

    // concurrent arrivals
    wait_idle();
    align(0);
    send(0, 8, 1'b1);
    send(1, 10, 1'b1);
    k = 0;
    while (done == '0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("cc done", 32'(done), 32'b11);

    wait_idle();
    repeat (2) @(negedge clk);
    chk("sb steps ch0", 32'(sq[0].size()), 32'd0);
    chk("sb steps ch1", 32'(sq[1].size()), 32'd0);
    chk("sb dones", 32'(dq[0].size() + dq[1].size()), 32'd0);

    // reset mid-move
    send(0, 11, 1'b1);
    k = 0;
    while (pos[7:0] != 8'd10 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("rm reached", 32'(pos[7:0]), 32'd10);
    #2 rst_n = 1'b0;
    #1;
    chk("rm pos", pos, 32'd0);
    chk("rm coil", 32'(coil), 32'd0);
    chk("rm pwm", 32'(pwm), 32'd0);
    chk("rm busy", 32'(busy), 32'd0);
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done != '0 || busy != '0) seen = 1'b1;
    end
    chk("rm quiet", 32'(seen), 32'd0);

    // three-channel build: out-of-range channel is swallowed
    ifc3.cmd_valid  = 1'b1;
    ifc3.cmd_ch     = 2'd3;
    ifc3.cmd_target = 8'd5;
    ifc3.cmd_half   = 1'b1;
    #1;
    chk("oor ready", 32'(ifc3.cmd_ready), 32'd1);
    @(negedge clk);
    ifc3.cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("oor busy", 32'(busy3), 32'd0);
    chk("oor pos", pos3, 32'd0);
    ifc3.cmd_valid  = 1'b1;
    ifc3.cmd_ch     = 2'd2;
    ifc3.cmd_target = 8'd1;
    #1;
    chk("ch2 ready", 32'(ifc3.cmd_ready), 32'd1);
    @(negedge clk);
    ifc3.cmd_valid = 1'b0;
    chk("ch2 busy", 32'(busy3), 32'b100);
    k = 0;
    while (!done3[2] && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("ch2 pos", 32'(pos3[23:16]), 32'd1);
    chk("ch2 coil", 32'(coil3[11:8]), 32'b1010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
